// File: rtl/muldiv_sched.sv
// muldiv_sched: two-slot MUL/DIV/HI-LO scheduler that shares one multiplier and one divider
// Ports: clk; rst (async, active-low); en1/en2, op1/op2, a1/b1/a2/b2 slot requests held in E;
//   flush_masterE/flush_slaveE/flush_exceptionM flushes; ex_advance E-stage advance;
//   mul_start/div_start/mul_sign/div_sign/md_abort/md_a/md_b and mul_ready/div_ready/mul_res/div_res
//   handshake with the shared units; hilo_q current HI:LO, hilo_we/hilo_wdata bundle write-back;
//   mul_lo MUL GPR result; stallE holds E while the bundle executes.
// Build option: define MULDIV_DUAL_EN to service slot2; otherwise en2 is ignored.
module muldiv_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        en1,
  input  logic        en2,
  input  logic [7:0]  op1,
  input  logic [7:0]  op2,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [31:0] a2,
  input  logic [31:0] b2,
  input  logic        flush_masterE,
  input  logic        flush_slaveE,
  input  logic        flush_exceptionM,
  input  logic        ex_advance,
  input  logic        mul_ready,
  input  logic        div_ready,
  input  logic [63:0] mul_res,
  input  logic [63:0] div_res,
  input  logic [63:0] hilo_q,
  output logic        mul_start,
  output logic        div_start,
  output logic        mul_sign,
  output logic        div_sign,
  output logic        md_abort,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        hilo_we,
  output logic [63:0] hilo_wdata,
  output logic [31:0] mul_lo,
  output logic        stallE
);
  localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1a, OP_DIVU = 8'h1b,
                         OP_MTHI = 8'h11, OP_MTLO = 8'h13, OP_MUL = 8'h42, OP_MADD = 8'h40,
                         OP_MADDU = 8'h41, OP_MSUB = 8'h44, OP_MSUBU = 8'h45;
  typedef enum logic [1:0] {IDLE, RUN1, RUN2, DONE} state_t;
  state_t state, state_n;
  logic [63:0] acc, acc_n, base, res;
  logic [31:0] a, b, mul_lo_n;
  logic [7:0] op;
  logic wrote, wrote_n, pend2, pend2_n, en2_v, run, s2;
  logic is_mul, is_div, is_mt, sgn, fin, keep, wr_acc;
`ifdef MULDIV_DUAL_EN
  assign en2_v = en2;
  // slot2 chains on slot1's result when slot1 produced one
  assign base  = wrote ? acc : hilo_q;
`else
  assign en2_v = 1'b0 & en2;
  assign base  = hilo_q;
`endif
  assign run    = state == RUN1 || state == RUN2;
  assign s2     = state == RUN2;
  assign op     = s2 ? op2 : op1;
  assign a      = s2 ? a2 : a1;
  assign b      = s2 ? b2 : b1;
  assign is_mul = op inside {OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  assign is_div = op inside {OP_DIV, OP_DIVU};
  assign is_mt  = op inside {OP_MTHI, OP_MTLO};
  assign sgn    = op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB, OP_DIV};
  assign fin    = run && (is_mul ? mul_ready : is_div ? div_ready : 1'b1);
  // a result is kept only if its slot survives this cycle's flushes
  assign keep   = fin && !flush_masterE && !(s2 && flush_slaveE);
  assign wr_acc = (is_mul && op != OP_MUL) || is_div || is_mt;
  assign res    = op == OP_MTHI ? {a, base[31:0]} :
                  op == OP_MTLO ? {base[63:32], a} :
                  op inside {OP_MADD, OP_MADDU} ? base + mul_res :
                  op inside {OP_MSUB, OP_MSUBU} ? base - mul_res :
                  is_div ? div_res : mul_res;
  always_comb begin
    state_n  = state;
    acc_n    = keep && wr_acc ? res : acc;
    wrote_n  = wrote || (keep && wr_acc);
    mul_lo_n = keep && op == OP_MUL ? mul_res[31:0] : mul_lo;
    pend2_n  = pend2 && !flush_slaveE;
    case (state)
      IDLE: begin
        state_n = en1 ? RUN1 : (en2_v && !flush_slaveE) ? RUN2 : IDLE;
        wrote_n = 1'b0;
        pend2_n = en2_v && !flush_slaveE;
      end
      RUN1:    state_n = fin ? (pend2_n ? RUN2 : DONE) : RUN1;
      RUN2:    state_n = (fin || flush_slaveE) ? DONE : RUN2;
      DONE:    state_n = ex_advance ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
    if (flush_masterE) begin
      state_n = IDLE;
      wrote_n = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      acc    <= '0;
      wrote  <= 1'b0;
      pend2  <= 1'b0;
      mul_lo <= '0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      wrote  <= wrote_n;
      pend2  <= pend2_n;
      mul_lo <= mul_lo_n;
    end
  end
  assign mul_start  = run && is_mul;
  assign div_start  = run && is_div;
  assign mul_sign   = mul_start && sgn;
  assign div_sign   = div_start && sgn;
  assign md_abort   = run && (is_mul || is_div) && (flush_masterE || (s2 && flush_slaveE));
  assign md_a       = run ? a : '0;
  assign md_b       = run ? b : '0;
  // reset gates stallE because IDLE alone would still raise it while a request is pending
  assign stallE     = rst && (run || (state == IDLE && (en1 || en2_v)));
  assign hilo_we    = state == DONE && ex_advance && wrote && !flush_exceptionM && !flush_masterE;
  assign hilo_wdata = hilo_we ? acc : '0;
endmodule
